// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns PCF, runs the req/ack handshake with instruction memory, holds the
// IF/ID register, and applies branch redirects and hazard stalls.
// Optional halt detection is built when IF_HALT_DET_EN is defined;
// otherwise halted is tied low and HALT_WORD is ordinary data.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
    parameter int unsigned HALT_COUNT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] cmd,
    output logic [31:0] PCPlusFourD,
    output logic        InstrValidD,
    output logic        halted
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pcf;
    logic [31:0] pc_plus4;
    logic [31:0] hold_word;
    logic [31:0] hold_pc4;
    logic        redirect_pend;
    logic [31:0] redirect_tgt;
    logic        stall;
    logic        ack;

    if (HALT_COUNT < 1) begin : g_bad_halt_count
        $error("HALT_COUNT must be at least 1");
    end

    assign stall     = StallF | StallD;
    assign pc_plus4  = pcf + 32'd4;
    assign imem_addr = pcf;
    // Request only while fetching; suppressed during reset and after halt.
    assign imem_req  = (state == FETCH) & ~halted & ~reset;
    assign ack       = imem_ack & imem_req;

`ifdef IF_HALT_DET_EN
    localparam int unsigned HCW = (HALT_COUNT < 2) ? 1 : $clog2(HALT_COUNT + 1);

    logic [HCW-1:0] halt_cnt;
    logic           halted_q;
    logic           accept;
    logic [31:0]    accept_word;

    // Identify a word being written into IF/ID this cycle (from memory or hold buffer).
    always_comb begin
        accept      = 1'b0;
        accept_word = hold_word;
        if (!halted_q) begin
            if (state == FETCH) begin
                if (ack && !redirect_pend && !PCSrcD && !stall) begin
                    accept      = 1'b1;
                    accept_word = imem_rdata;
                end
            end else if (!stall && !PCSrcD) begin
                accept = 1'b1;
            end
        end
    end

    // Count consecutive accepted HALT_WORDs; stop fetching for good at HALT_COUNT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt_cnt <= '0;
            halted_q <= 1'b0;
        end else if (accept) begin
            if (accept_word == HALT_WORD) begin
                halt_cnt <= halt_cnt + 1'b1;
                if (halt_cnt == HCW'(HALT_COUNT - 1))
                    halted_q <= 1'b1;
            end else begin
                halt_cnt <= '0;
            end
        end
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    // Fetch FSM: PC update, hold buffer, redirect tracking and the IF/ID register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= FETCH;
            pcf           <= RESET_PC;
            cmd           <= '0;
            PCPlusFourD   <= '0;
            InstrValidD   <= 1'b0;
            hold_word     <= '0;
            hold_pc4      <= '0;
            redirect_pend <= 1'b0;
            redirect_tgt  <= '0;
        end else if (halted) begin
            cmd         <= '0;
            InstrValidD <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!ack) begin
                        if (!StallD) begin
                            cmd         <= '0;
                            InstrValidD <= 1'b0;
                        end
                        // Address must stay stable until ack, so remember the target.
                        if (PCSrcD && !StallD && !redirect_pend) begin
                            redirect_pend <= 1'b1;
                            redirect_tgt  <= PCBranchD;
                        end
                    end else if (redirect_pend) begin
                        // Word belongs to the squashed path: drop it and jump.
                        pcf           <= redirect_tgt;
                        redirect_pend <= 1'b0;
                        if (!StallD) begin
                            cmd         <= '0;
                            InstrValidD <= 1'b0;
                        end
                    end else if (PCSrcD && !StallD) begin
                        pcf         <= PCBranchD;
                        cmd         <= '0;
                        InstrValidD <= 1'b0;
                    end else if (!stall) begin
                        cmd         <= imem_rdata;
                        PCPlusFourD <= pc_plus4;
                        InstrValidD <= 1'b1;
                        pcf         <= pc_plus4;
                    end else begin
                        hold_word <= imem_rdata;
                        hold_pc4  <= pc_plus4;
                        state     <= HOLD;
                        if (!StallD) begin
                            cmd         <= '0;
                            InstrValidD <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (PCSrcD && !StallD) begin
                        pcf         <= PCBranchD;
                        cmd         <= '0;
                        InstrValidD <= 1'b0;
                        state       <= FETCH;
                    end else if (!stall) begin
                        cmd         <= hold_word;
                        PCPlusFourD <= hold_pc4;
                        InstrValidD <= 1'b1;
                        pcf         <= hold_pc4;
                        state       <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a transaction-level model predicts the
// fetch address stream, the accepted instruction stream and per-cycle status;
// a negedge monitor compares what the DUT presents.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;
    localparam int          HALT_COUNT = 5;

    logic        clk;
    logic        reset;
    logic        StallF, StallD, PCSrcD;
    logic [31:0] PCBranchD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] cmd;
    logic [31:0] PCPlusFourD;
    logic        InstrValidD;
    logic        halted;

    if_fetch_stage #(
        .RESET_PC   (RESET_PC),
        .HALT_WORD  (HALT_WORD),
        .HALT_COUNT (HALT_COUNT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .StallF      (StallF),
        .StallD      (StallD),
        .PCSrcD      (PCSrcD),
        .PCBranchD   (PCBranchD),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .cmd         (cmd),
        .PCPlusFourD (PCPlusFourD),
        .InstrValidD (InstrValidD),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc4;
    } instr_t;

    typedef struct packed {
        logic req;
        logic valid;
        logic halt;
    } cyc_t;

    instr_t      exp_instr_q[$];
    logic [31:0] exp_addr_q[$];
    cyc_t        exp_cyc_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model state: program counter, word parked by a stall, pending redirect.
    logic [31:0] m_pc;
    bit          m_parked;
    logic [31:0] m_park_w, m_park_p4;
    bit          m_pend;
    logic [31:0] m_tgt;
    bit          m_halted;
    bit          m_valid;
    int          m_hcnt;

    function automatic void start_fetch(input logic [31:0] a);
        m_pc = a;
        if (!m_halted) exp_addr_q.push_back(a);
    endfunction

    function automatic void deliver(input logic [31:0] w, input logic [31:0] p4);
        m_valid = 1'b1;
        exp_instr_q.push_back('{word: w, pc4: p4});
`ifdef IF_HALT_DET_EN
        m_hcnt = (w == HALT_WORD) ? m_hcnt + 1 : 0;
        if (m_hcnt == HALT_COUNT) m_halted = 1'b1;
`endif
    endfunction

    function automatic void model_reset();
        m_pc = RESET_PC; m_parked = 0; m_pend = 0; m_halted = 0; m_valid = 0; m_hcnt = 0;
        m_park_w = '0; m_park_p4 = '0; m_tgt = '0;
        exp_instr_q.delete(); exp_addr_q.delete(); exp_cyc_q.delete();
    endfunction

    function automatic void model_release();
        exp_cyc_q.push_back('{req: 1'b1, valid: 1'b0, halt: 1'b0});
        exp_addr_q.push_back(RESET_PC);
    endfunction

    // One clock of the model, using the inputs as the DUT samples them.
    function automatic void model_step();
        bit requesting, got_word, stalled, redirect_now;
        requesting   = !m_parked && !m_halted;
        got_word     = requesting && imem_ack;
        stalled      = StallF || StallD;
        redirect_now = PCSrcD && !StallD;
        if (m_halted) begin
            m_valid = 1'b0;
        end else if (m_parked) begin
            if (redirect_now) begin
                m_parked = 0; m_valid = 1'b0; start_fetch(PCBranchD);
            end else if (!stalled) begin
                m_parked = 0; deliver(m_park_w, m_park_p4); start_fetch(m_park_p4);
            end
        end else if (!got_word) begin
            if (!StallD) m_valid = 1'b0;
            if (redirect_now && !m_pend) begin m_pend = 1; m_tgt = PCBranchD; end
        end else if (m_pend) begin
            m_pend = 0;
            if (!StallD) m_valid = 1'b0;
            start_fetch(m_tgt);
        end else if (redirect_now) begin
            m_valid = 1'b0; start_fetch(PCBranchD);
        end else if (!stalled) begin
            deliver(imem_rdata, m_pc + 32'd4); start_fetch(m_pc + 32'd4);
        end else begin
            m_parked = 1; m_park_w = imem_rdata; m_park_p4 = m_pc + 32'd4;
            if (!StallD) m_valid = 1'b0;
        end
        exp_cyc_q.push_back('{req: !m_parked && !m_halted, valid: m_valid, halt: m_halted});
    endfunction

    // Monitor: compares DUT outputs against the scoreboard queues.
    bit          prev_req, prev_ack, prev_valid;
    logic [31:0] prev_addr, prev_pc4;

    always @(negedge clk) begin
        cyc_t   c;
        instr_t e;
        bit     new_req;
        if (reset) begin
            check32("rst_req", {31'b0, imem_req}, 32'd0);
            check32("rst_addr", imem_addr, RESET_PC);
            check32("rst_cmd", cmd, 32'd0);
            check32("rst_pc4", PCPlusFourD, 32'd0);
            check32("rst_valid", {31'b0, InstrValidD}, 32'd0);
            check32("rst_halted", {31'b0, halted}, 32'd0);
            prev_req = 0; prev_ack = 0; prev_valid = 0;
        end else begin
            if (exp_cyc_q.size() == 0) begin
                check32("cyc_underflow", 32'd1, 32'd0);
            end else begin
                c = exp_cyc_q.pop_front();
                check32("req", {31'b0, imem_req}, {31'b0, c.req});
                check32("valid", {31'b0, InstrValidD}, {31'b0, c.valid});
                check32("halted", {31'b0, halted}, {31'b0, c.halt});
            end
            if (!InstrValidD) check32("bubble_cmd", cmd, 32'd0);
            if (prev_req && !prev_ack && imem_req)
                check32("addr_stable", imem_addr, prev_addr);
            new_req = imem_req && (!prev_req || prev_ack);
            if (new_req) begin
                if (exp_addr_q.size() == 0) check32("unexpected_req", imem_addr, 32'hxxxx_xxxx);
                else check32("fetch_addr", imem_addr, exp_addr_q.pop_front());
            end
            if (InstrValidD && !(prev_valid && prev_pc4 == PCPlusFourD)) begin
                if (exp_instr_q.size() == 0) begin
                    check32("unexpected_instr", cmd, 32'hxxxx_xxxx);
                end else begin
                    e = exp_instr_q.pop_front();
                    check32("cmd", cmd, e.word);
                    check32("pc4", PCPlusFourD, e.pc4);
                end
            end
            prev_req = imem_req; prev_ack = imem_ack; prev_valid = InstrValidD;
            prev_addr = imem_addr; prev_pc4 = PCPlusFourD;
        end
    end

    // Stimulus: directed warm-up, a run of halt words, then randomized traffic.
    initial begin
        int rst_left;
        reset = 1'b1; StallF = 0; StallD = 0; PCSrcD = 0; PCBranchD = '0;
        imem_ack = 0; imem_rdata = '0;
        model_reset();
        rst_left = 3;
        for (int cyc = 0; cyc < 4200; cyc++) begin
            @(posedge clk);
            if (!reset) model_step();
            #1;
            if (reset) begin
                if (rst_left > 0) rst_left--;
                else begin reset = 1'b0; model_release(); end
            end else if (cyc > 60 && $urandom_range(0, 119) == 0) begin
                reset = 1'b1; model_reset(); rst_left = $urandom_range(0, 2);
            end
            if (cyc < 25) begin
                StallF = 0; StallD = 0; PCSrcD = 0;
                imem_ack = 1'b1; imem_rdata = imem_addr | 32'h1000_0000;
            end else if (cyc < 60) begin
                StallF = 0; StallD = 0; PCSrcD = 0;
                imem_ack = ($urandom_range(0, 1) == 0); imem_rdata = HALT_WORD;
            end else begin
                StallF    = ($urandom_range(0, 5) == 0);
                StallD    = ($urandom_range(0, 5) == 0);
                PCSrcD    = ($urandom_range(0, 7) == 0);
                PCBranchD = 32'($urandom_range(0, 63)) << 2;
                imem_ack  = ($urandom_range(0, 2) == 0);
                imem_rdata = ($urandom_range(0, 2) == 0) ? HALT_WORD : 32'($urandom);
            end
        end
        @(negedge clk);
        #1;
        if (!reset) begin
            check32("instr_q_drained", 32'(exp_instr_q.size()), 32'd0);
            check32("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
